// File: rtl/sid_reg_shadow.sv
// sid_reg_shadow: host-written SID register shadow RAM with dirty-entry round-robin forwarding to the SID bus.
// Optional clear engine (clr port) enabled by defining SID_SHADOW_CLR_EN.
module sid_reg_shadow #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int CH_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SID_SHADOW_CLR_EN
  input  logic               clr,
`endif
  input  logic               wr_en,
  input  logic [CH_BITS-1:0] wr_ch,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [CH_BITS-1:0] rd_ch,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               sid_req,
  input  logic               sid_ack,
  output logic [CH_BITS-1:0] sid_ch,
  output logic [ADDR_W-1:0]  sid_addr,
  output logic [DATA_W-1:0]  sid_data,
  output logic               busy
);
  localparam int IDX_W = CH_BITS + ADDR_W;
  localparam int N     = 2 ** IDX_W;
  typedef enum logic {SCAN, ISSUE} state_t;
  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt, w_wr_idx, w_clr_idx;
  logic [N-1:0]        r_dirty, w_dirty_nxt;
  logic [DATA_W-1:0]   r_mem [N];
  logic [CH_BITS-1:0]  r_sid_ch;
  logic [ADDR_W-1:0]   r_sid_addr;
  logic [DATA_W-1:0]   r_sid_data;
  logic                w_latch, w_clr_we;
  assign w_wr_idx = {wr_ch, wr_addr};
`ifdef SID_SHADOW_CLR_EN
  logic             r_clr_act;
  logic [IDX_W-1:0] r_clr_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_act <= 1'b0;
      r_clr_idx <= '0;
    end else if (clr) begin
      r_clr_act <= 1'b1;
      r_clr_idx <= '0;
    end else if (r_clr_act) begin
      r_clr_act <= ~&r_clr_idx;
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end
  assign w_clr_we  = r_clr_act;
  assign w_clr_idx = r_clr_idx;
`else
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif
  // Host write is ordered last so it wins over a clear at the same index.
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_idx] <= '0;
    if (wr_en) r_mem[w_wr_idx] <= wr_data;
  end
  assign rd_data = r_mem[{rd_ch, rd_addr}];
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_latch     = 1'b0;
    if (r_state == SCAN) begin
      if (r_dirty[r_ptr]) begin
        w_latch     = 1'b1;
        w_state_nxt = ISSUE;
      end else w_ptr_nxt = r_ptr + 1'b1;
    end else if (sid_ack) begin
      w_state_nxt = SCAN;
      w_ptr_nxt   = r_ptr + 1'b1;
    end
  end
  // Sets are applied after the latch clear so a colliding write keeps the entry dirty.
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (w_latch) w_dirty_nxt[r_ptr] = 1'b0;
    if (w_clr_we) w_dirty_nxt[w_clr_idx] = 1'b1;
    if (wr_en) w_dirty_nxt[w_wr_idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SCAN;
      r_ptr      <= '0;
      r_dirty    <= '0;
      r_sid_ch   <= '0;
      r_sid_addr <= '0;
      r_sid_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dirty <= w_dirty_nxt;
      if (w_latch) begin
        r_sid_ch   <= r_ptr[IDX_W-1:ADDR_W];
        r_sid_addr <= r_ptr[ADDR_W-1:0];
        r_sid_data <= r_mem[r_ptr];
      end
    end
  end
  assign sid_req  = (r_state == ISSUE);
  assign sid_ch   = r_sid_ch;
  assign sid_addr = r_sid_addr;
  assign sid_data = r_sid_data;
  assign busy     = |r_dirty | sid_req | w_clr_we;
endmodule

// File: tb/tb_sid_reg_shadow.sv
// tb_sid_reg_shadow: scoreboard bench for sid_reg_shadow; forwarded writes are compared against queued expectations.
module tb_sid_reg_shadow;
  localparam int DATA_W = 8, ADDR_W = 5, CH_BITS = 1, IDX_W = 6, N = 64;
  logic clk = 0, rst, wr_en, sid_ack, sid_req, busy;
  logic [CH_BITS-1:0] wr_ch, rd_ch, sid_ch;
  logic [ADDR_W-1:0]  wr_addr, rd_addr, sid_addr;
  logic [DATA_W-1:0]  wr_data, rd_data, sid_data;
  logic [IDX_W+DATA_W-1:0] exp_q[$];
  logic [IDX_W+DATA_W-1:0] e;
  int total = 0, bad = 0;
  bit ok;
`ifdef SID_SHADOW_CLR_EN
  logic clr;
`endif
  always #5 clk = ~clk;
  sid_reg_shadow dut (
    .clk(clk), .rst(rst),
`ifdef SID_SHADOW_CLR_EN
    .clr(clr),
`endif
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .sid_req(sid_req), .sid_ack(sid_ack), .sid_ch(sid_ch), .sid_addr(sid_addr),
    .sid_data(sid_data), .busy(busy)
  );

  task automatic write(input logic [CH_BITS-1:0] ch, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit push);
    wr_en = 1; wr_ch = ch; wr_addr = a; wr_data = d;
    if (push) exp_q.push_back({ch, a, d});
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wait_req(output bit found);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (sid_req) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_ack();
    sid_ack = 1;
    @(negedge clk);
    sid_ack = 0;
  endtask

  task automatic test_reset();
    total++;
    if (sid_req !== 1'b0 || busy !== 1'b0 || {sid_ch, sid_addr, sid_data} !== '0) begin
      bad++;
      $display("FAIL reset: req=%b busy=%b sid=%h want 0/0/0", sid_req, busy, {sid_ch, sid_addr, sid_data});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    write(0, 5'h18, 8'h0F, 1);
    rd_ch = 0; rd_addr = 5'h18;
    total++;
    if (rd_data !== 8'h0F) begin bad++; $display("FAIL basic_rd: got %h want 0f", rd_data); end
    wait_req(ok);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
      bad++; $display("FAIL basic_req: ok=%b got %h want %h", ok, {sid_ch, sid_addr, sid_data}, e);
    end
    do_ack();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
    ok = 1;
    for (int i = 0; i < 80; i++) begin
      if (sid_req) ok = 0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL basic_idle: extra req seen, want none"); end
  endtask

  task automatic test_coalesce();
    write(0, 5'h1F, 8'h77, 1);
    wait_req(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
      bad++; $display("FAIL coalesce_blocker: ok=%b got %h want %h", ok, {sid_ch, sid_addr, sid_data}, e);
    end
    write(1, 5'h04, 8'h11, 0);
    write(1, 5'h04, 8'h41, 1);
    do_ack();
    wait_req(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
      bad++; $display("FAIL coalesce_req: ok=%b got %h want %h", ok, {sid_ch, sid_addr, sid_data}, e);
    end
    do_ack();
    ok = 1;
    for (int i = 0; i < 80; i++) begin
      if (sid_req) ok = 0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL coalesce_single: second req seen, want one"); end
  endtask

  task automatic test_hold();
    write(0, 5'h01, 8'h55, 1);
    wait_req(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
      bad++; $display("FAIL hold_first: ok=%b got %h want %h", ok, {sid_ch, sid_addr, sid_data}, e);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) write(0, 5'h00, 8'hAA, 1);
      else @(negedge clk);
    end
    total++;
    if (sid_req !== 1'b1 || {sid_ch, sid_addr, sid_data} !== {1'b0, 5'h01, 8'h55}) begin
      bad++; $display("FAIL hold_stable: req=%b got %h want 1/%h", sid_req, {sid_ch, sid_addr, sid_data}, {1'b0, 5'h01, 8'h55});
    end
    do_ack();
    wait_req(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
      bad++; $display("FAIL hold_next: ok=%b got %h want %h", ok, {sid_ch, sid_addr, sid_data}, e);
    end
    do_ack();
  endtask

  task automatic test_collision();
    write(0, 5'h04, 8'h44, 1);
    wait_req(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
      bad++; $display("FAIL coll_pre: ok=%b got %h want %h", ok, {sid_ch, sid_addr, sid_data}, e);
    end
    write(0, 5'h05, 8'h50, 1);
    do_ack();
    write(0, 5'h05, 8'h5A, 1);
    for (int k = 0; k < 2; k++) begin
      wait_req(ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || {sid_ch, sid_addr, sid_data} !== e) begin
        bad++; $display("FAIL coll_req%0d: ok=%b got %h want %h", k, ok, {sid_ch, sid_addr, sid_data}, e);
      end
      do_ack();
    end
    rd_ch = 0; rd_addr = 5'h05;
    total++;
    if (rd_data !== 8'h5A) begin bad++; $display("FAIL coll_rd: got %h want 5a", rd_data); end
  endtask

  task automatic test_reset_mid();
    write(1, 5'h02, 8'h33, 0);
    wait_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_req: no req, want one"); end
    rst = 1;
    #1;
    total++;
    if (sid_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop: req=%b busy=%b want 0/0", sid_req, busy);
    end
    @(negedge clk);
    rst = 0;
    ok = 1;
    for (int i = 0; i < 80; i++) begin
      if (sid_req) ok = 0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_idle: req after reset, want none"); end
    rd_ch = 1; rd_addr = 5'h02;
    total++;
    if (rd_data !== 8'h33) begin bad++; $display("FAIL rstmid_ram: got %h want 33", rd_data); end
  endtask

`ifdef SID_SHADOW_CLR_EN
  task automatic test_clear();
    int cnt;
    bit zero;
    clr = 1;
    @(negedge clk);
    clr = 0;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      wait_req(ok);
      if (!ok) break;
      total++;
      if (sid_data !== 8'h00) begin bad++; $display("FAIL clear_data: got %h want 00", sid_data); end
      cnt++;
      do_ack();
    end
    repeat (80) begin
      if (sid_req) begin cnt++; do_ack(); end
      else @(negedge clk);
    end
    total++;
    if (cnt != N) begin bad++; $display("FAIL clear_count: got %0d want %0d", cnt, N); end
    zero = 1;
    for (int i = 0; i < N; i++) begin
      {rd_ch, rd_addr} = IDX_W'(i);
      #1;
      if (rd_data !== 8'h00) zero = 0;
    end
    total++;
    if (!zero) begin bad++; $display("FAIL clear_ram: nonzero readback, want all 00"); end
  endtask
`endif

  initial begin
    rst = 1; wr_en = 0; wr_ch = 0; wr_addr = 0; wr_data = 0; sid_ack = 0; rd_ch = 0; rd_addr = 0;
`ifdef SID_SHADOW_CLR_EN
    clr = 0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_coalesce();
    test_hold();
    test_collision();
    test_reset_mid();
`ifdef SID_SHADOW_CLR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
